command_decode: RTL

Decode stage of the CPU pipeline. It sits directly downstream of the command buffer, which pairs fetched 14-bit words into 28-bit commands. The block requests commands from the buffer and splits each one into opcode, register and immediate fields. It tracks pending register writes in a scoreboard, holds dependent commands, and issues them one at a time to execute over a valid/ready handshake.

---
 rtl/command_decode.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/command_decode.sv
// Decode stage: pulls 28-bit commands from the command buffer, splits them into fields,
// blocks commands whose registers have pending writes, and issues them to execute.
module command_decode #(
  parameter int DATA_W = 14,
  parameter int REGS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*DATA_W-1:0]   command_in,
  output logic                  cmd_req,
  input  logic                  cmd_stall,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [3:0]            ex_opcode,
  output logic [3:0]            ex_ra,
  output logic [3:0]            ex_rb,
  output logic [1:0]            ex_mode,
  output logic [DATA_W-1:0]     ex_imm,
  output logic                  ex_wr_en,
  input  logic                  wb_valid,
  input  logic [3:0]            wb_reg,
  input  logic                  br_done,
  output logic                  illegal_op,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAIT_BR = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_STOR = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_MOVI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic op_writes_ra(input logic [3:0] op);
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOVI: op_writes_ra = 1'b1;
      default:                                                 op_writes_ra = 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_ra(input logic [3:0] op);
    case (op)
      OP_STOR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_JZ: op_reads_ra = 1'b1;
      default:                                               op_reads_ra = 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_rb(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_reads_rb = 1'b1;
      default:                               op_reads_rb = 1'b0;
    endcase
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    case (op)
      4'hB, 4'hC, 4'hD, 4'hE: op_illegal = 1'b1;
      default:                op_illegal = 1'b0;
    endcase
  endfunction

  state_t              state_r, state_s;
  logic [REGS-1:0]     busy_r, busy_s;
  logic                rd_ra_r, rd_rb_r;
  logic                hazard_s, accept_s, issue_s, cmd_req_s, ex_valid_s;
  logic [3:0]          in_op_s, in_ra_s, in_rb_s;
  logic [1:0]          in_mode_s;
  logic [DATA_W-1:0]   in_imm_s;

  assign in_op_s   = command_in[2*DATA_W-1 -: 4];
  assign in_ra_s   = command_in[DATA_W+9 -: 4];
  assign in_rb_s   = command_in[DATA_W+5 -: 4];
  assign in_mode_s = command_in[DATA_W+1 -: 2];
  assign in_imm_s  = command_in[DATA_W-1:0];

  // Read-after-write and write-after-write hazards, from registered busy only
  assign hazard_s = ((rd_ra_r | ex_wr_en) & busy_r[ex_ra]) | (rd_rb_r & busy_r[ex_rb]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (!cmd_stall) begin
          if (in_op_s == OP_HALT) begin
            state_s = ST_HALTED;
          end else if ((in_op_s == OP_NOP) || op_illegal(in_op_s)) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_HOLD;
          end
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (issue_s) begin
          state_s = ((ex_opcode == OP_JMP) || (ex_opcode == OP_JZ)) ? ST_WAIT_BR : ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_WAIT_BR: begin
        if (br_done) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_WAIT_BR;
        end
      end
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_FETCH;
    endcase
  end

  // Handshake outputs; forced low while reset is asserted
  always_comb begin
    cmd_req_s  = 1'b0;
    ex_valid_s = 1'b0;
    if (!reset) begin
      cmd_req_s  = (state_r == ST_FETCH);
      ex_valid_s = (state_r == ST_HOLD) && !hazard_s;
    end else begin
      cmd_req_s  = 1'b0;
      ex_valid_s = 1'b0;
    end
    accept_s = cmd_req_s && !cmd_stall;
    issue_s  = ex_valid_s && ex_ready;
  end

  assign cmd_req  = cmd_req_s;
  assign ex_valid = ex_valid_s;

  // Field registers, loaded whenever the buffer hands over a command
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_opcode <= 4'h0;
      ex_ra     <= 4'h0;
      ex_rb     <= 4'h0;
      ex_mode   <= 2'b00;
      ex_imm    <= '0;
      ex_wr_en  <= 1'b0;
      rd_ra_r   <= 1'b0;
      rd_rb_r   <= 1'b0;
    end else if (accept_s) begin
      ex_opcode <= in_op_s;
      ex_ra     <= in_ra_s;
      ex_rb     <= in_rb_s;
      ex_mode   <= in_mode_s;
      ex_imm    <= in_imm_s;
      ex_wr_en  <= op_writes_ra(in_op_s);
      rd_ra_r   <= op_reads_ra(in_op_s);
      rd_rb_r   <= op_reads_rb(in_op_s);
    end
  end

  // Scoreboard update: writeback clears first, an issuing write sets last so it wins
  always_comb begin
    busy_s = busy_r;
    if (wb_valid) begin
      busy_s[wb_reg] = 1'b0;
    end else begin
      busy_s = busy_r;
    end
    if (issue_s && ex_wr_en) begin
      busy_s[ex_ra] = 1'b1;
    end else begin
      busy_s = busy_s;
    end
  end

  // Scoreboard and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= '0;
      illegal_op <= 1'b0;
      halted     <= 1'b0;
    end else begin
      busy_r <= busy_s;
      if (accept_s && op_illegal(in_op_s)) begin
        illegal_op <= 1'b1;
      end
      if (accept_s && (in_op_s == OP_HALT)) begin
        halted <= 1'b1;
      end
    end
  end

endmodule
